// File: rtl/sparse_match.sv
// Sparse activation/weight match engine: walks the AND of two sparsity bitmaps and emits
// compressed-buffer address pairs for every match. Define SPARSE_MATCH_STAT_EN for statistics counters.
module sparse_match #(
    parameter int FLAG_WIDTH = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLAG_WIDTH-1:0] act_flag,
    input  logic [FLAG_WIDTH-1:0] wei_flag,
    input  logic [ADDR_WIDTH-1:0] act_base,
    input  logic [ADDR_WIDTH-1:0] wei_base,
    output logic [IDX_WIDTH:0]    match_cnt,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [IDX_WIDTH-1:0]  pair_pos,
    output logic [ADDR_WIDTH-1:0] act_addr,
    output logic [ADDR_WIDTH-1:0] wei_addr,
    output logic                  pair_last,
    output logic                  row_done
`ifdef SPARSE_MATCH_STAT_EN
    ,
    output logic [15:0]           stat_pairs,
    output logic [15:0]           stat_skip_rows
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [FLAG_WIDTH-1:0]   act_flag_q, wei_flag_q;
    logic [FLAG_WIDTH-1:0]   mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]   act_base_q, wei_base_q;
    logic [IDX_WIDTH:0]      match_cnt_q;

    logic [FLAG_WIDTH-1:0]   in_mask;
    logic [FLAG_WIDTH-1:0]   low_bit;
    logic [FLAG_WIDTH-1:0]   below_mask;
    logic [IDX_WIDTH-1:0]    pos;
    logic                    accept;
    logic                    last;

    function automatic logic [IDX_WIDTH:0] popcount(input logic [FLAG_WIDTH-1:0] v);
        logic [IDX_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < FLAG_WIDTH; i++) begin
            c = c + {{IDX_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign in_mask    = act_flag & wei_flag;
    assign accept     = (state_q == IDLE) && in_valid && !flush;

    // Isolate the lowest set bit; everything below it is the set of earlier stored elements.
    assign low_bit    = mask_q & (~mask_q + FLAG_WIDTH'(1));
    assign below_mask = low_bit - FLAG_WIDTH'(1);
    assign last       = (state_q == SCAN) && ((mask_q & (mask_q - FLAG_WIDTH'(1))) == '0);

    always_comb begin
        pos = '0;
        for (int i = FLAG_WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) pos = IDX_WIDTH'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    mask_d  = in_mask;
                    state_d = (in_mask != '0) ? SCAN : DONE;
                end
                SCAN: if (pair_ready) begin
                    mask_d = mask_q & ~low_bit;
                    if (last) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            act_flag_q  <= '0;
            wei_flag_q  <= '0;
            act_base_q  <= '0;
            wei_base_q  <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (accept) begin
                act_flag_q  <= act_flag;
                wei_flag_q  <= wei_flag;
                act_base_q  <= act_base;
                wei_base_q  <= wei_base;
                match_cnt_q <= popcount(in_mask);
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign pair_valid = (state_q == SCAN);
    assign row_done   = (state_q == DONE);
    assign match_cnt  = match_cnt_q;
    assign pair_pos   = pos;
    assign pair_last  = last;
    assign act_addr   = act_base_q +
                        {{(ADDR_WIDTH-IDX_WIDTH-1){1'b0}}, popcount(act_flag_q & below_mask)};
    assign wei_addr   = wei_base_q +
                        {{(ADDR_WIDTH-IDX_WIDTH-1){1'b0}}, popcount(wei_flag_q & below_mask)};

`ifdef SPARSE_MATCH_STAT_EN
    logic [15:0] stat_pairs_q, stat_skip_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pairs_q <= '0;
            stat_skip_q  <= '0;
        end else begin
            if (pair_valid && pair_ready && stat_pairs_q != 16'hFFFF)
                stat_pairs_q <= stat_pairs_q + 16'd1;
            if (accept && in_mask == '0 && stat_skip_q != 16'hFFFF)
                stat_skip_q <= stat_skip_q + 16'd1;
        end
    end

    assign stat_pairs     = stat_pairs_q;
    assign stat_skip_rows = stat_skip_q;
`endif

endmodule
